// File: rtl/cdc_hs_tx.sv
// -----------------------------------------------------------------------------
// cdc_hs_tx
//   clk_a-side transmitter of a 4-phase req/ack handshake. One DATA_W word is
//   accepted from a valid/ready source, held on data_out, and req_out is raised.
//   The clk_b receiver acks, and req_out then drops. When the synchronized ack
//   falls, the transfer completes and xfer_done pulses for one cycle.
//
//   Optional feature macro: CDC_HS_TX_TIMEOUT_EN
//     defined   : a sticky timeout_err is set after TIMEOUT_CYC cycles spent
//                 waiting in REQ or RELEASE. The FSM keeps waiting.
//     undefined : timeout_err is tied 0.
//
// Ports
//   clk_a        in   transmitter clock
//   arstn        in   async active-low reset
//   din          in   word to send
//   din_valid    in   din presented
//   din_ready    out  block accepts din this cycle
//   data_out     out  held word toward clk_b, stable while req_out=1
//   req_out      out  registered handshake request
//   ack_in       in   receiver acknowledge (asynchronous to clk_a)
//   busy         out  transfer in flight
//   xfer_done    out  one-cycle pulse at handshake completion
//   timeout_err  out  sticky timeout flag
// -----------------------------------------------------------------------------
module cdc_hs_tx #(
    parameter int DATA_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_a,
    input  logic              arstn,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              req_out,
    input  logic              ack_in,
    output logic              busy,
    output logic              xfer_done,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_ff;
    logic                   ack_sync;

    // ack_in crosses from clk_b; only the last stage is used by the logic.
    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) ack_ff <= '0;
        else        ack_ff <= {ack_ff[SYNC_STAGES-2:0], ack_in};
    end
    assign ack_sync = ack_ff[SYNC_STAGES-1];

    // A lingering high ack from a previous transfer blocks new accepts.
    assign din_ready = (state == IDLE) && !ack_sync;

    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            state     <= IDLE;
            data_out  <= '0;
            req_out   <= 1'b0;
            busy      <= 1'b0;
            xfer_done <= 1'b0;
        end else begin
            xfer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (din_valid && !ack_sync) begin
                        data_out <= din;
                        req_out  <= 1'b1;
                        busy     <= 1'b1;
                        state    <= REQ;
                    end
                end
                REQ: begin
                    if (ack_sync) begin
                        req_out <= 1'b0;
                        state   <= RELEASE;
                    end
                end
                RELEASE: begin
                    // data_out stays frozen until the next accept
                    if (!ack_sync) begin
                        xfer_done <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    req_out <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef CDC_HS_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_inc;
    logic             leaving;

    assign wait_inc = wait_cnt + 1'b1;
    // The counter restarts on every state change so REQ and RELEASE are timed
    // separately.
    assign leaving  = (state == REQ && ack_sync) || (state == RELEASE && !ack_sync);

    always_ff @(posedge clk_a or negedge arstn) begin
        if (!arstn) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else if (state == IDLE || leaving) begin
            wait_cnt <= '0;
        end else if (wait_cnt != CNT_W'(TIMEOUT_CYC)) begin
            wait_cnt <= wait_inc;
            if (wait_inc == CNT_W'(TIMEOUT_CYC)) timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule
